// File: rtl/config_sequencer_pkg.sv
// Shared constants, state encoding and beat helper for the configuration-bus sequencer.
// Address map: 0-63 PE, 64 memory, 65-127 network.
package config_sequencer_pkg;

    localparam int CFG_NUM_PE = 64;
    localparam int CFG_ADDR_W = 7;
    localparam int CFG_DATA_W = 16;
    localparam logic [CFG_ADDR_W-1:0] CFG_ADDR_MEM = 7'd64;
    localparam logic [CFG_ADDR_W-1:0] CFG_ADDR_NET = 7'd65;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } cfg_state_t;

    // Address beats carry the 7-bit target zero-extended to the bus width.
    function automatic logic [CFG_DATA_W-1:0] addr_beat(input logic [CFG_ADDR_W-1:0] addr);
        return {9'b0, addr};
    endfunction

endpackage

// File: rtl/config_sequencer_fifo.sv
// Synchronous request FIFO; full/empty come from pointers carrying one extra wrap bit.
// A pop never frees space for a push in the same cycle because full is taken from registers.
module cfg_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W:0]   wr_ptr_r;
    logic [PTR_W:0]   rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                       (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign pop_data  = mem_r[rd_ptr_r[PTR_W-1:0]];

    // Pointer update; reset empties the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {(PTR_W+1){1'b0}};
            rd_ptr_r <= {(PTR_W+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + (PTR_W+1)'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + (PTR_W+1)'(1);
            end
        end
    end

    // Entry storage needs no reset: slots are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[PTR_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/config_sequencer.sv
// Serialises queued (addr, data) writes onto the two-beat configuration bus: address, data, gap.
// Optional CFG_BROADCAST_EN macro expands a broadcast request into 64 PE writes.
module config_sequencer
    import config_sequencer_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [CFG_ADDR_W-1:0] req_addr,
    input  logic [CFG_DATA_W-1:0] req_data,
    input  logic                  req_bcast,
    output logic [CFG_DATA_W-1:0] cfg_data,
    output logic                  cfg_valid,
    input  logic                  cfg_ready,
    output logic                  busy,
    output logic [15:0]           write_count
);

`ifdef CFG_BROADCAST_EN
    localparam int ENTRY_W = 1 + CFG_ADDR_W + CFG_DATA_W;
`else
    localparam int ENTRY_W = CFG_ADDR_W + CFG_DATA_W;
`endif
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    cfg_state_t            state_r;
    logic                  cfg_valid_r;
    logic [CFG_DATA_W-1:0] cfg_data_r;
    logic [CFG_DATA_W-1:0] data_q_r;
    logic [GAP_W-1:0]      gap_cnt_r;
    logic [15:0]           write_count_r;

    logic [ENTRY_W-1:0]    push_entry_s;
    logic [ENTRY_W-1:0]    pop_entry_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic                  pop_s;
    logic [CFG_ADDR_W-1:0] pop_addr_s;
    logic [CFG_DATA_W-1:0] pop_data_s;

`ifdef CFG_BROADCAST_EN
    logic                  bcast_q_r;
    logic [5:0]            bcast_cnt_r;
    logic                  pop_bcast_s;

    assign push_entry_s = {req_bcast, req_addr, req_data};
    assign pop_bcast_s  = pop_entry_s[ENTRY_W-1];
`else
    logic                  unused_bcast_s;

    assign push_entry_s   = {req_addr, req_data};
    assign unused_bcast_s = req_bcast;
`endif

    assign pop_data_s = pop_entry_s[CFG_DATA_W-1:0];
    assign pop_addr_s = pop_entry_s[CFG_DATA_W +: CFG_ADDR_W];
    assign pop_s      = (state_r == ST_IDLE) && !fifo_empty_s;

    assign req_ready   = !fifo_full_s;
    assign busy        = !fifo_empty_s || (state_r != ST_IDLE);
    assign cfg_valid   = cfg_valid_r;
    assign cfg_data    = cfg_data_r;
    assign write_count = write_count_r;

    cfg_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_valid),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .pop_data  (pop_entry_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Bus FSM; outputs are loaded together with the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            cfg_valid_r   <= 1'b0;
            cfg_data_r    <= 16'd0;
            data_q_r      <= 16'd0;
            gap_cnt_r     <= {GAP_W{1'b0}};
            write_count_r <= 16'd0;
`ifdef CFG_BROADCAST_EN
            bcast_q_r     <= 1'b0;
            bcast_cnt_r   <= 6'd0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!fifo_empty_s) begin
                        data_q_r    <= pop_data_s;
                        cfg_valid_r <= 1'b1;
                        state_r     <= ST_ADDR;
`ifdef CFG_BROADCAST_EN
                        bcast_q_r   <= pop_bcast_s;
                        bcast_cnt_r <= 6'd0;
                        cfg_data_r  <= pop_bcast_s ? addr_beat(7'd0) : addr_beat(pop_addr_s);
`else
                        cfg_data_r  <= addr_beat(pop_addr_s);
`endif
                    end
                end
                ST_ADDR: begin
                    if (cfg_ready) begin
                        cfg_data_r <= data_q_r;
                        state_r    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // Data beat lasts one cycle whatever the receiver's ready says.
                    cfg_valid_r   <= 1'b0;
                    cfg_data_r    <= 16'd0;
                    write_count_r <= write_count_r + 16'd1;
                    gap_cnt_r     <= {GAP_W{1'b0}};
                    state_r       <= ST_GAP;
                end
                ST_GAP: begin
                    if (gap_cnt_r == GAP_LAST) begin
`ifdef CFG_BROADCAST_EN
                        if (bcast_q_r && (bcast_cnt_r != 6'd63)) begin
                            bcast_cnt_r <= bcast_cnt_r + 6'd1;
                            cfg_valid_r <= 1'b1;
                            cfg_data_r  <= addr_beat({1'b0, bcast_cnt_r + 6'd1});
                            state_r     <= ST_ADDR;
                        end else begin
                            state_r <= ST_IDLE;
                        end
`else
                        state_r <= ST_IDLE;
`endif
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GAP_W'(1);
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cfg_valid_r <= 1'b0;
                    cfg_data_r  <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_sequencer.sv
// Bench for config_sequencer: transaction-level bus model plus directed vectors.
// The broadcast case runs only when CFG_BROADCAST_EN is defined.
module tb_config_sequencer;

    localparam int DEPTH = 4;
    localparam int GAP   = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  req_addr;
    logic [15:0] req_data;
    logic        req_bcast;
    logic [15:0] cfg_data;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        busy;
    logic [15:0] write_count;

    config_sequencer #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_bcast   (req_bcast),
        .cfg_data    (cfg_data),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .busy        (busy),
        .write_count (write_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected write stream and receiver-side register bank
    typedef struct {
        logic [6:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_q[$];
    bit          expect_data = 1'b0;
    bit          addr_hold   = 1'b0;
    int          gap_left    = 0;
    logic [15:0] beats       = 16'd0;
    logic [6:0]  cur_addr;
    logic [15:0] pe_bank [64];
    logic [15:0] mem_reg;
    logic [15:0] net_bank [128];

    // Compare process: each accepted request must appear as addr beat, data beat, then GAP idle cycles.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_valid", {31'b0, cfg_valid}, 32'd0);
            chk("rst_data", {16'b0, cfg_data}, 32'd0);
            chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
            chk("rst_busy", {31'b0, busy}, 32'd0);
            chk("rst_write_count", {16'b0, write_count}, 32'd0);
            exp_q.delete();
            expect_data = 1'b0;
            addr_hold   = 1'b0;
            gap_left    = 0;
            beats       = 16'd0;
        end else begin
            chk("write_count", {16'b0, write_count}, {16'b0, beats});
            if (expect_data) begin
                chk("data_valid", {31'b0, cfg_valid}, 32'd1);
                chk("data_word", {16'b0, cfg_data}, {16'b0, exp_q[0].data});
                if (cur_addr < 7'd64) pe_bank[cur_addr[5:0]] = cfg_data;
                else if (cur_addr == 7'd64) mem_reg = cfg_data;
                else net_bank[cur_addr] = cfg_data;
                void'(exp_q.pop_front());
                beats       = beats + 16'd1;
                expect_data = 1'b0;
                gap_left    = GAP;
            end else if (gap_left > 0) begin
                chk("gap_valid", {31'b0, cfg_valid}, 32'd0);
                chk("gap_data", {16'b0, cfg_data}, 32'd0);
                gap_left--;
            end else if (cfg_valid) begin
                if (exp_q.size() == 0) begin
                    chk("beat_with_nothing_queued", {31'b0, cfg_valid}, 32'd0);
                end else begin
                    chk("addr_word", {16'b0, cfg_data}, {25'b0, exp_q[0].addr});
                    cur_addr    = cfg_data[6:0];
                    expect_data = cfg_ready;
                    addr_hold   = !cfg_ready;
                end
            end else begin
                if (addr_hold) chk("addr_hold_valid", {31'b0, cfg_valid}, 32'd1);
                chk("idle_data", {16'b0, cfg_data}, 32'd0);
                addr_hold = 1'b0;
            end
            if (req_valid && req_ready) begin
`ifdef CFG_BROADCAST_EN
                if (req_bcast) begin
                    for (int i = 0; i < 64; i++) exp_q.push_back('{addr: 7'(i), data: req_data});
                end else begin
                    exp_q.push_back('{addr: req_addr, data: req_data});
                end
`else
                exp_q.push_back('{addr: req_addr, data: req_data});
`endif
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a request and return just after the edge that accepts it; req_valid stays high.
    task automatic push(input logic [6:0] a, input logic [15:0] d, input logic b);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_bcast = b;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        chk("push_timeout", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            #1;
            done = !busy && exp_q.size() == 0 && !expect_data && gap_left == 0;
        end
        if (!done) chk("idle_timeout", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_addr_beat(input logic [15:0] word);
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = cfg_valid && cfg_data == word;
        end
        if (!seen) chk("addr_beat_timeout", {16'b0, cfg_data}, {16'b0, word});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = 7'd0;
        req_data  = 16'd0;
        req_bcast = 1'b0;
        cfg_ready = 1'b1;
        tick(3);
        rst = 1'b0;
        chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
        chk("post_rst_busy", {31'b0, busy}, 32'd0);

        // 1: single write, exact beat timing
        push(7'd5, 16'hA5A5, 1'b0);
        req_valid = 1'b0;
        @(negedge clk);
        chk("t1_busy_n1", {31'b0, busy}, 32'd1);
        chk("t1_valid_n1", {31'b0, cfg_valid}, 32'd0);
        @(negedge clk);
        chk("t1_addr_n2", {15'b0, cfg_valid, cfg_data}, 32'h0001_0005);
        @(negedge clk);
        chk("t1_data_n3", {15'b0, cfg_valid, cfg_data}, 32'h0001_A5A5);
        @(negedge clk);
        chk("t1_gap_valid", {31'b0, cfg_valid}, 32'd0);
        chk("t1_count", {16'b0, write_count}, 32'd1);
        wait_idle(50);

        // 2: receiver stalls the address beat
        cfg_ready = 1'b0;
        push(7'd9, 16'h1234, 1'b0);
        req_valid = 1'b0;
        wait_addr_beat(16'h0009);
        repeat (10) begin
            @(negedge clk);
            chk("t2_stall", {15'b0, cfg_valid, cfg_data}, 32'h0001_0009);
        end
        @(posedge clk);
        #1;
        cfg_ready = 1'b1;
        @(negedge clk);
        chk("t2_addr_ready", {15'b0, cfg_valid, cfg_data}, 32'h0001_0009);
        @(negedge clk);
        chk("t2_data", {15'b0, cfg_valid, cfg_data}, 32'h0001_1234);
        wait_idle(50);

        // 3: five back-to-back pushes against a stalled bus fill the FIFO
        cfg_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(7'(10 + i), 16'(16'h1100 + i), 1'b0);
        req_addr = 7'd15;
        req_data = 16'hDEAD;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_full", {31'b0, req_ready}, 32'd0);
            chk("t3_busy", {31'b0, busy}, 32'd1);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        cfg_ready = 1'b1;
        wait_idle(200);
        chk("t3_count", {16'b0, write_count}, 32'd7);
        chk("t3_last_pe", {16'b0, pe_bank[14]}, 32'h1104);
        chk("t3_first_pe", {16'b0, pe_bank[10]}, 32'h1100);

        // 4: reset during the data beat of a memory write
        push(7'd64, 16'hBEEF, 1'b0);
        req_valid = 1'b0;
        wait_addr_beat(16'h0040);
        @(posedge clk);
        #1;
        chk("t4_in_data", {16'b0, cfg_data}, 32'h0000_BEEF);
        rst = 1'b1;
        #1;
        chk("t4_valid", {31'b0, cfg_valid}, 32'd0);
        chk("t4_data", {16'b0, cfg_data}, 32'd0);
        chk("t4_busy", {31'b0, busy}, 32'd0);
        chk("t4_count", {16'b0, write_count}, 32'd0);
        tick(2);
        rst = 1'b0;
        push(7'd100, 16'h7777, 1'b0);
        req_valid = 1'b0;
        wait_idle(50);
        chk("t4_restart_count", {16'b0, write_count}, 32'd1);
        chk("t4_restart_net", {16'b0, net_bank[100]}, 32'h7777);

        // 6: register bank sees PE, memory and network writes
        push(7'd3, 16'h0303, 1'b0);
        push(7'd64, 16'h4040, 1'b0);
        push(7'd100, 16'h6464, 1'b0);
        req_valid = 1'b0;
        wait_idle(100);
        chk("t6_pe3", {16'b0, pe_bank[3]}, 32'h0303);
        chk("t6_mem", {16'b0, mem_reg}, 32'h4040);
        chk("t6_net100", {16'b0, net_bank[100]}, 32'h6464);
        chk("t6_count", {16'b0, write_count}, 32'd4);

`ifdef CFG_BROADCAST_EN
        // 5: broadcast expands into 64 PE writes; its address field is ignored
        push(7'd100, 16'h0F0F, 1'b1);
        req_valid = 1'b0;
        req_bcast = 1'b0;
        wait_idle(1000);
        chk("t5_count", {16'b0, write_count}, 32'd68);
        chk("t5_pe0", {16'b0, pe_bank[0]}, 32'h0F0F);
        chk("t5_pe3", {16'b0, pe_bank[3]}, 32'h0F0F);
        chk("t5_pe63", {16'b0, pe_bank[63]}, 32'h0F0F);
        chk("t5_net_untouched", {16'b0, net_bank[100]}, 32'h6464);
`else
        // 5: without broadcast support req_bcast is a plain single write
        push(7'd7, 16'h0777, 1'b1);
        req_valid = 1'b0;
        req_bcast = 1'b0;
        wait_idle(50);
        chk("t5_count", {16'b0, write_count}, 32'd5);
        chk("t5_pe7", {16'b0, pe_bank[7]}, 32'h0777);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
